ahb_slave_mem: RTL and testbench

- Downstream consumer of the four-way slave select: one AHB-Lite memory slave. Four instances, one per hsel_N line, form the slave set.
- Samples the address phase when selected and drives a data phase with hreadyout, hresp and hrdata back to the bus mux.
- Supports a configurable number of wait states on NONSEQ beats, zero-wait SEQ beats inside bursts, and two-cycle ERROR responses.

---
 rtl/ahb_pkg.sv | 51 +++++
 rtl/ahb_sram_array.sv | 24 ++
 rtl/ahb_slave_mem.sv | 127 ++++++++++++
 tb/tb_ahb_slave_mem.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // hreadyout seen by the bus while the slave sits in a given state
    function automatic logic state_ready(slave_state_e s);
        logic r;
        case (s)
            ST_WAIT, ST_ERR1: r = 1'b0;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    // hresp seen by the bus while the slave sits in a given state
    function automatic logic state_resp(slave_state_e s);
        logic r;
        case (s)
            ST_ERR1, ST_ERR2: r = HRESP_ERROR;
            default:          r = HRESP_OKAY;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide storage for the memory slave: synchronous write, asynchronous read.
module ahb_sram_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Commit a write at the end of the write data-phase cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: wait states on NONSEQ, zero-wait SEQ, two-cycle ERROR.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    slave_state_e      state_r, state_next_s;
    logic [3:0]        cnt_r, cnt_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic              write_r;
    logic              hreadyout_r, hresp_r;
    logic [DATA_W-1:0] hrdata_hold_r;
    logic [DATA_W-1:0] rdata_s;
    logic              accept_s, illegal_s, capture_s, rd_phase_s, mem_we_s;
    logic              unused_burst_s;

    // The burst type carries no behaviour here
    assign unused_burst_s = ^hburst;

    assign accept_s   = hsel & hready_in & htrans[1];
    assign illegal_s  = (hsize != HSIZE_WORD) | (haddr[1:0] != 2'b00) | (|haddr[ADDR_W-1:IDX_W+2]);
    assign rd_phase_s = (state_r == ST_DATA) & ~write_r;
    assign mem_we_s   = (state_r == ST_DATA) & write_r;

    // Next-state and wait-counter decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    capture_s = 1'b1;
                    if (illegal_s) begin
                        state_next_s = ST_ERR1;
                    end else if ((htrans == HTRANS_NONSEQ) && (WAIT_CYCLES > 0)) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_DATA;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_ERR1: state_next_s = ST_ERR2;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, captured transfer and registered bus responses
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            idx_r         <= '0;
            write_r       <= 1'b0;
            hreadyout_r   <= 1'b1;
            hresp_r       <= HRESP_OKAY;
            hrdata_hold_r <= '0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            hreadyout_r <= state_ready(state_next_s);
            hresp_r     <= state_resp(state_next_s);
            if (capture_s) begin
                idx_r   <= haddr[IDX_W+1:2];
                write_r <= hwrite;
            end
            if (rd_phase_s) begin
                hrdata_hold_r <= rdata_s;
            end
        end
    end

    // Read data is live only in a read data phase; otherwise the last value is held
    always_comb begin
        if (rd_phase_s) begin
            hrdata = rdata_s;
        end else begin
            hrdata = hrdata_hold_r;
        end
    end

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;

    ahb_sram_array #(
        .DEPTH  (MEM_DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (hclk),
        .we    (mem_we_s),
        .idx   (idx_r),
        .wdata (hwdata),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized bench for ahb_slave_mem against a transaction-level memory/bus model.
module tb_ahb_slave_mem;

    localparam int W     = 2;
    localparam int DEPTH = 256;
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } tx_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        rd;
        logic        wr;
        int          idx;
        logic [31:0] wdata;
    } ph_t;

    logic        hclk = 1'b0;
    logic        hreset, hsel, hwrite, hready_in;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;

    tx_t         txq[$];
    ph_t         phq[$];
    logic [1:0]  pat_q[$];
    logic [31:0] rd_seen_q[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rdata, exp_rdata, prior;
    logic        exp_rdy, exp_resp, chk_en;
    int          n_cmp, n_fail, lows;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready_in(hready_in), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
    );

    // Per-cycle comparison of bus outputs against the model expectation
    always @(negedge hclk) begin
        if (chk_en) begin
            n_cmp++;
            if ({hreadyout, hresp, hrdata} !== {exp_rdy, exp_resp, exp_rdata}) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got rdy/resp/rdata %b/%b/%h want %b/%b/%h",
                         $time, hreadyout, hresp, hrdata, exp_rdy, exp_resp, exp_rdata);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic write, input logic [2:0] size, input logic [31:0] wdata);
        tx_t t;
        t.sel = sel; t.trans = trans; t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
        txq.push_back(t);
    endtask

    // One bus cycle: set this cycle's expectation, drive inputs, advance to the next edge
    task automatic step();
        ph_t cur;
        ph_t ph;
        tx_t t;
        if (phq.size() > 0) begin
            cur = phq.pop_front();
        end else begin
            cur.rdy = 1'b1; cur.resp = 1'b0; cur.rd = 1'b0; cur.wr = 1'b0; cur.idx = 0; cur.wdata = 32'h0;
        end
        if (cur.rd) begin
            last_rdata = mem_m[cur.idx];
            rd_seen_q.push_back(hrdata);
        end
        exp_rdy   = cur.rdy;
        exp_resp  = cur.resp;
        exp_rdata = last_rdata;
        hready_in = cur.rdy;
        hwdata    = cur.wr ? cur.wdata : $urandom();
        if (cur.rdy) begin
            if (txq.size() > 0) begin
                t = txq.pop_front();
            end else begin
                t.sel = 1'b0; t.trans = 2'b00; t.addr = $urandom(); t.write = 1'b0;
                t.size = 3'b010; t.wdata = 32'h0;
            end
            hsel = t.sel; haddr = t.addr; htrans = t.trans; hwrite = t.write; hsize = t.size;
            hburst = 3'($urandom_range(7, 0));
            if (cur.wr) mem_m[cur.idx] = cur.wdata;
            if (t.sel && (t.trans == 2'b10 || t.trans == 2'b11)) begin
                if (t.size != 3'b010 || (t.addr % 4) != 0 || t.addr >= 32'(4 * DEPTH)) begin
                    ph.rd = 1'b0; ph.wr = 1'b0; ph.idx = 0; ph.wdata = 32'h0;
                    ph.rdy = 1'b0; ph.resp = 1'b1; phq.push_back(ph);
                    ph.rdy = 1'b1; ph.resp = 1'b1; phq.push_back(ph);
                end else begin
                    ph.rdy = 1'b0; ph.resp = 1'b0; ph.rd = 1'b0; ph.wr = 1'b0; ph.idx = 0; ph.wdata = 32'h0;
                    if (t.trans == 2'b10) repeat (W) phq.push_back(ph);
                    ph.rdy = 1'b1; ph.rd = ~t.write; ph.wr = t.write;
                    ph.idx = int'(t.addr / 4); ph.wdata = t.wdata;
                    phq.push_back(ph);
                end
            end
        end else begin
            hsel = 1'($urandom_range(1, 0)); haddr = $urandom(); htrans = 2'($urandom_range(3, 0));
            hwrite = 1'($urandom_range(1, 0));
        end
        @(posedge hclk);
        #1;
    endtask

    // Run until every queued transfer has completed its data phase
    task automatic drain();
        int guard;
        guard = 0;
        lows  = 0;
        pat_q.delete();
        rd_seen_q.delete();
        while ((txq.size() > 0 || phq.size() > 0) && guard < 3000) begin
            step();
            guard++;
            pat_q.push_back({hreadyout, hresp});
            if (hreadyout === 1'b0) lows++;
        end
        if (guard >= 3000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout got %0d cycles want fewer than 3000", guard);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; chk_en = 1'b0;
        hreset = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; hwdata = 32'h0; hready_in = 1'b1;
        exp_rdy = 1'b1; exp_resp = 1'b0; exp_rdata = 32'h0; last_rdata = 32'h0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        lit("reset_hreadyout", 32'(hreadyout), 32'd1);
        lit("reset_hresp", 32'(hresp), 32'd0);
        lit("reset_hrdata", hrdata, 32'h0);
        chk_en = 1'b1;

        // fill the whole array with one NONSEQ + SEQ burst
        for (int i = 0; i < DEPTH; i++)
            push_tx(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'(4 * i), 1'b1, 3'b010, $urandom());
        drain();

        // basic write then read
        push_tx(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF);
        push_tx(1'b1, 2'b10, 32'h10, 1'b0, 3'b010, 32'h0);
        drain();
        lit("basic_wr_ready_seq", 32'({pat_q[0], pat_q[1], pat_q[2]}), 32'b00_00_10);
        lit("basic_read_resp", 32'(pat_q[5]), 32'b10);
        lit("basic_read_data", rd_seen_q[0], 32'hDEADBEEF);

        // INCR4 write burst then read-back burst
        for (int i = 0; i < 4; i++)
            push_tx(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'(32'h20 + 4 * i), 1'b1, 3'b010, 32'(i + 1));
        drain();
        lit("burst_wr_waits", 32'(lows), 32'(W));
        lit("burst_wr_cycles", 32'(pat_q.size() - 1), 32'(W + 4));
        for (int i = 0; i < 4; i++)
            push_tx(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'(32'h20 + 4 * i), 1'b0, 3'b010, 32'h0);
        drain();
        lit("burst_rd_waits", 32'(lows), 32'(W));
        for (int i = 0; i < 4; i++) lit("burst_rd_data", rd_seen_q[i], 32'(i + 1));

        // illegal size: two-cycle ERROR, memory untouched
        prior = mem_m[16];
        push_tx(1'b1, 2'b10, 32'h40, 1'b1, 3'b000, 32'hFFFFFFFF);
        drain();
        lit("size_err_seq", 32'({pat_q[0], pat_q[1]}), 32'b01_11);
        push_tx(1'b1, 2'b10, 32'h40, 1'b0, 3'b010, 32'h0);
        drain();
        lit("size_err_mem", rd_seen_q[0], prior);

        // out of range then misaligned, back to back
        push_tx(1'b1, 2'b10, 32'h400, 1'b1, 3'b010, 32'h11111111);
        push_tx(1'b1, 2'b10, 32'h12, 1'b1, 3'b010, 32'h22222222);
        drain();
        lit("oor_misalign_seq", 32'({pat_q[0], pat_q[1], pat_q[2], pat_q[3]}), 32'b01_11_01_11);

        // reset in the second wait cycle of a write aborts it
        prior = mem_m[12];
        push_tx(1'b1, 2'b10, 32'h30, 1'b1, 3'b010, 32'hA5A55A5A);
        step();
        step();
        hreset = 1'b1;
        phq.delete();
        last_rdata = 32'h0;
        exp_rdy = 1'b1; exp_resp = 1'b0; exp_rdata = 32'h0;
        hready_in = 1'b1; hsel = 1'b0; htrans = 2'b00;
        #1;
        lit("midrst_hreadyout", 32'(hreadyout), 32'd1);
        lit("midrst_hresp", 32'(hresp), 32'd0);
        lit("midrst_hrdata", hrdata, 32'h0);
        @(posedge hclk);
        #1 hreset = 1'b0;
        push_tx(1'b1, 2'b10, 32'h30, 1'b0, 3'b010, 32'h0);
        drain();
        lit("midrst_readback", rd_seen_q[0], prior);

        // BUSY, unselected and IDLE: zero-wait OKAY, no access
        push_tx(1'b1, 2'b01, 32'h50, 1'b1, 3'b010, 32'h33333333);
        push_tx(1'b0, 2'b10, 32'h50, 1'b1, 3'b010, 32'h44444444);
        push_tx(1'b1, 2'b00, 32'h50, 1'b1, 3'b010, 32'h55555555);
        drain();
        lit("idle_busy_waits", 32'(lows), 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(19, 0);
            if (r == 0)      a = 32'h400 + 32'(4 * $urandom_range(63, 0));
            else if (r == 1) a = 32'(4 * $urandom_range(DEPTH - 1, 0) + $urandom_range(3, 1));
            else if (r < 8)  a = 32'(4 * $urandom_range(3, 0));
            else             a = 32'(4 * $urandom_range(DEPTH - 1, 0));
            push_tx(1'($urandom_range(9, 0) != 0), 2'($urandom_range(3, 0)), a,
                    1'($urandom_range(1, 0)),
                    ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'b010, $urandom());
        end
        drain();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
